// File: rtl/tl_cntr_timed_if.sv
// rtl/tl_cntr_timed_if.sv - sensor inputs and lamp/phase outputs of the timed traffic-light controller
interface tl_cntr_timed_if;
  logic       Ta;
  logic       Tal;
  logic       Tb;
  logic       Tbl;
  logic [1:0] La;
  logic [1:0] Lb;
  logic [2:0] phase;
  logic       maxout;

  modport master (
    output Ta, Tal, Tb, Tbl,
    input  La, Lb, phase, maxout
  );

  modport slave (
    input  Ta, Tal, Tb, Tbl,
    output La, Lb, phase, maxout
  );
endinterface

// File: rtl/tl_cntr_timed.sv
// rtl/tl_cntr_timed.sv - two-road traffic-light controller with left-turn phases, min/max green and left-turn skip
module tl_cntr_timed #(
  parameter int YELLOW_CYC = 3,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 16,
  parameter int CNT_W      = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  tl_cntr_timed_if.slave bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_LEFT   = 2'b10;
  localparam logic [1:0] L_RED    = 2'b11;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             maxout_q, maxout_d;
  logic             t_sel;
  logic             hold_exit;
  logic             yel_exit;
  logic             at_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S0;
      cnt_q    <= '0;
      maxout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      maxout_q <= maxout_d;
    end
  end

  // Demand sensor owning the current hold state; yellow states ignore it.
  always_comb begin
    t_sel = 1'b0;
    case (state_q)
      S0:      t_sel = bus.Ta;
      S2:      t_sel = bus.Tal;
      S4:      t_sel = bus.Tb;
      S6:      t_sel = bus.Tbl;
      default: t_sel = 1'b0;
    endcase
  end

  assign at_max    = (cnt_q == MAX_LAST);
  assign hold_exit = ((cnt_q >= MIN_LAST) && !t_sel) || at_max;
  assign yel_exit  = (cnt_q == YEL_LAST);

  always_comb begin
    state_d  = state_q;
    maxout_d = 1'b0;
    case (state_q)
      S0: if (hold_exit) state_d = S1;
      S1: if (yel_exit)  state_d = bus.Tal ? S2 : S4;
      S2: if (hold_exit) state_d = S3;
      S3: if (yel_exit)  state_d = S4;
      S4: if (hold_exit) state_d = S5;
      S5: if (yel_exit)  state_d = bus.Tbl ? S6 : S0;
      S6: if (hold_exit) state_d = S7;
      S7: if (yel_exit)  state_d = S0;
      default:           state_d = S0;
    endcase
    // A forced end only counts when demand was still present at the cut-off.
    if (!state_q[0] && at_max && t_sel) maxout_d = 1'b1;
  end

  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    bus.La = L_RED;
    bus.Lb = L_RED;
    case (state_q)
      S0:      begin bus.La = L_GREEN;  bus.Lb = L_RED;    end
      S1:      begin bus.La = L_YELLOW; bus.Lb = L_RED;    end
      S2:      begin bus.La = L_LEFT;   bus.Lb = L_RED;    end
      S3:      begin bus.La = L_YELLOW; bus.Lb = L_RED;    end
      S4:      begin bus.La = L_RED;    bus.Lb = L_GREEN;  end
      S5:      begin bus.La = L_RED;    bus.Lb = L_YELLOW; end
      S6:      begin bus.La = L_RED;    bus.Lb = L_LEFT;   end
      S7:      begin bus.La = L_RED;    bus.Lb = L_YELLOW; end
      default: begin bus.La = L_RED;    bus.Lb = L_RED;    end
    endcase
    bus.phase  = state_q;
    bus.maxout = maxout_q;
  end

endmodule

// File: tb/tb_tl_cntr_timed.sv
// tb/tb_tl_cntr_timed.sv - randomized and directed self-checking bench for tl_cntr_timed
module tb_tl_cntr_timed;
  localparam int YC = 3;
  localparam int MN = 4;
  localparam int MX = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ph[$];
  int   exp_mo[$];

  tl_cntr_timed_if bus ();

  tl_cntr_timed #(.YELLOW_CYC(YC), .MIN_GREEN(MN), .MAX_GREEN(MX), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int lamp_a(int ph);
    case (ph)
      0: return 0;
      1, 3: return 1;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int lamp_b(int ph);
    case (ph)
      4: return 0;
      5, 7: return 1;
      6: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic push_seq(int ph, int n, int first_mo);
    for (int i = 0; i < n; i++) begin
      exp_ph.push_back(ph);
      exp_mo.push_back((i == 0) ? first_mo : 0);
    end
  endtask

  task automatic set_in(logic a, logic al, logic b, logic bl);
    bus.Ta = a; bus.Tal = al; bus.Tb = b; bus.Tbl = bl;
  endtask

  // Leaves time just after reset release, before the first rising edge.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.phase, bus.La, bus.Lb, bus.maxout} !== {3'd0, 2'b00, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got ph=%0d La=%0d Lb=%0d mo=%0d, want ph=0 La=0 Lb=3 mo=0",
               bus.phase, bus.La, bus.Lb, bus.maxout);
    end
  endtask

  task automatic test_all_zero();
    exp_ph.delete(); exp_mo.delete();
    for (int r = 0; r < 2; r++) begin
      push_seq(0, 4, 0); push_seq(1, 3, 0); push_seq(4, 4, 0); push_seq(5, 3, 0);
    end
    do_reset();
    for (int i = 0; i < exp_ph.size(); i++) begin
      set_in(0, 0, 0, 0);
      n_cmp++;
      if (bus.phase !== 3'(exp_ph[i]) || bus.maxout !== 1'(exp_mo[i]) ||
          bus.La !== 2'(lamp_a(exp_ph[i])) || bus.Lb !== 2'(lamp_b(exp_ph[i]))) begin
        n_err++;
        $display("FAIL all_zero[%0d]: got ph=%0d mo=%0d La=%0d Lb=%0d, want ph=%0d mo=%0d",
                 i, bus.phase, bus.maxout, bus.La, bus.Lb, exp_ph[i], exp_mo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_left_max();
    exp_ph.delete(); exp_mo.delete();
    push_seq(0, 4, 0); push_seq(1, 3, 0); push_seq(2, 16, 0); push_seq(3, 3, 1);
    push_seq(4, 4, 0); push_seq(5, 3, 0); push_seq(6, 16, 0); push_seq(7, 3, 1);
    push_seq(0, 1, 0);
    do_reset();
    for (int i = 0; i < exp_ph.size(); i++) begin
      set_in(0, 1, 0, 1);
      n_cmp++;
      if (bus.phase !== 3'(exp_ph[i]) || bus.maxout !== 1'(exp_mo[i]) ||
          bus.La !== 2'(lamp_a(exp_ph[i])) || bus.Lb !== 2'(lamp_b(exp_ph[i]))) begin
        n_err++;
        $display("FAIL left_max[%0d]: got ph=%0d mo=%0d La=%0d Lb=%0d, want ph=%0d mo=%0d",
                 i, bus.phase, bus.maxout, bus.La, bus.Lb, exp_ph[i], exp_mo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ta_max();
    exp_ph.delete(); exp_mo.delete();
    push_seq(0, 16, 0); push_seq(1, 3, 1); push_seq(4, 1, 0);
    do_reset();
    for (int i = 0; i < exp_ph.size(); i++) begin
      set_in(1, 0, 0, 0);
      n_cmp++;
      if (bus.phase !== 3'(exp_ph[i]) || bus.maxout !== 1'(exp_mo[i])) begin
        n_err++;
        $display("FAIL ta_max[%0d]: got ph=%0d mo=%0d, want ph=%0d mo=%0d",
                 i, bus.phase, bus.maxout, exp_ph[i], exp_mo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ta_gap();
    exp_ph.delete(); exp_mo.delete();
    push_seq(0, 8, 0); push_seq(1, 3, 0); push_seq(4, 1, 0);
    do_reset();
    for (int i = 0; i < exp_ph.size(); i++) begin
      set_in(i < 7, 0, 0, 0);
      n_cmp++;
      if (bus.phase !== 3'(exp_ph[i]) || bus.maxout !== 1'(exp_mo[i])) begin
        n_err++;
        $display("FAIL ta_gap[%0d]: got ph=%0d mo=%0d, want ph=%0d mo=%0d",
                 i, bus.phase, bus.maxout, exp_ph[i], exp_mo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_tb_short();
    exp_ph.delete(); exp_mo.delete();
    push_seq(0, 4, 0); push_seq(1, 3, 0); push_seq(4, 4, 0); push_seq(5, 3, 0); push_seq(0, 2, 0);
    do_reset();
    for (int i = 0; i < exp_ph.size(); i++) begin
      set_in(0, 0, (i == 7 || i == 8), 0);
      n_cmp++;
      if (bus.phase !== 3'(exp_ph[i]) || bus.maxout !== 1'(exp_mo[i])) begin
        n_err++;
        $display("FAIL tb_short[%0d]: got ph=%0d mo=%0d, want ph=%0d mo=%0d",
                 i, bus.phase, bus.maxout, exp_ph[i], exp_mo[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_s4();
    int waited = 0;
    do_reset();
    set_in(0, 0, 1, 0);
    while (bus.phase !== 3'd4 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    if (bus.phase !== 3'd4 || bus.Lb !== 2'b00) begin
      n_err++;
      $display("FAIL reach_s4: got ph=%0d Lb=%0d after %0d cycles, want ph=4 Lb=0",
               bus.phase, bus.Lb, waited);
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.phase, bus.La, bus.Lb, bus.maxout} !== {3'd0, 2'b00, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset_s4: got ph=%0d La=%0d Lb=%0d mo=%0d, want ph=0 La=0 Lb=3 mo=0",
               bus.phase, bus.La, bus.Lb, bus.maxout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    set_in(0, 0, 0, 0);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.phase !== ((i < 4) ? 3'd0 : 3'd1)) begin
        n_err++;
        $display("FAIL post_reset_hold[%0d]: got ph=%0d, want ph=%0d", i, bus.phase, (i < 4) ? 0 : 1);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reference: phase plus number of completed dwell cycles, advanced by the phase rules.
  task automatic test_random();
    int   ph = 0, dw = 0, mo = 0, done, nph, nmo;
    logic a = 0, al = 0, b = 0, bl = 0, t;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) a  = ~a;
      if ($urandom_range(0, 7) == 0) al = ~al;
      if ($urandom_range(0, 7) == 0) b  = ~b;
      if ($urandom_range(0, 7) == 0) bl = ~bl;
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0; #1; reset_n = 1'b1;
        ph = 0; dw = 0; mo = 0;
      end
      set_in(a, al, b, bl);
      n_cmp++;
      if (bus.phase !== 3'(ph) || bus.maxout !== 1'(mo) ||
          bus.La !== 2'(lamp_a(ph)) || bus.Lb !== 2'(lamp_b(ph))) begin
        n_err++;
        $display("FAIL random[%0d]: got ph=%0d mo=%0d La=%0d Lb=%0d, want ph=%0d mo=%0d La=%0d Lb=%0d",
                 i, bus.phase, bus.maxout, bus.La, bus.Lb, ph, mo, lamp_a(ph), lamp_b(ph));
      end
      done = dw + 1;
      nph  = ph;
      nmo  = 0;
      if (ph % 2 == 0) begin
        t = (ph == 0) ? a : (ph == 2) ? al : (ph == 4) ? b : bl;
        if ((done >= MN && !t) || done >= MX) begin
          nph = ph + 1;
          nmo = (done >= MX && t) ? 1 : 0;
        end
      end else if (done >= YC) begin
        case (ph)
          1: nph = al ? 2 : 4;
          3: nph = 4;
          5: nph = bl ? 6 : 0;
          default: nph = 0;
        endcase
      end
      dw = (nph != ph) ? 0 : done;
      ph = nph;
      mo = nmo;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    test_reset();
    test_all_zero();
    test_left_max();
    test_ta_max();
    test_ta_gap();
    test_tb_short();
    test_reset_mid_s4();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
